// File: rtl/score_display_driver.sv
`default_nettype none
// score_display_driver: sequential double-dabble binary->BCD converter feeding
// a time-multiplexed two-digit common 7-segment display. Rev 1.0
module score_display_driver #(
  parameter int BW          = 7,
  parameter int REFRESH_DIV = 1000,
  parameter int MAX_VAL     = 99
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] value_i,
  output logic [3:0]    bcd_tens_o,
  output logic [3:0]    bcd_ones_o,
  output logic          valid_o,
  output logic          busy_o,
  output logic          overflow_o,
  output logic [6:0]    seg_o,
  output logic [1:0]    dig_sel_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(BW + 1);
  localparam int DW = 12 + BW;

  localparam logic [CW-1:0] C_REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] C_SHIFT_LAST   = SW'(BW - 1);
  localparam logic [SW-1:0] C_SHIFT_ONE    = SW'(1);
  localparam logic [CW-1:0] C_REFRESH_ONE  = CW'(1);
  localparam logic [BW:0]   C_MAX_CMP      = (BW + 1)'(MAX_VAL);

  localparam logic [1:0] C_SEL_ONES = 2'b01;
  localparam logic [1:0] C_SEL_TENS = 2'b10;
  localparam logic [6:0] C_SEG_BLANK = 7'h00;
  localparam logic [6:0] C_SEG_DASH  = 7'h40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic          start_pend;
  logic [BW-1:0] last_val;
  logic [BW-1:0] bin;
  logic [11:0]   bcd;
  logic [SW-1:0] shift_cnt;

  logic [11:0]   bcd_adj;
  logic [DW-1:0] dd_word;
  logic [DW-1:0] dd_next;

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    sel_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

  // Add-3 correction on every BCD nibble, then one combined left shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    dd_word = {bcd_adj, bin};
    dd_next = dd_word << 1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      start_pend <= 1'b1;
      last_val   <= '0;
      bin        <= '0;
      bcd        <= '0;
      shift_cnt  <= '0;
      bcd_tens_o <= 4'd0;
      bcd_ones_o <= 4'd0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pend || (value_i != last_val)) begin
            bin        <= value_i;
            last_val   <= value_i;
            bcd        <= '0;
            shift_cnt  <= '0;
            start_pend <= 1'b0;
            busy_o     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd       <= dd_next[DW-1:BW];
          bin       <= dd_next[BW-1:0];
          shift_cnt <= shift_cnt + C_SHIFT_ONE;
          if (shift_cnt == C_SHIFT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_tens_o <= bcd[7:4];
          bcd_ones_o <= bcd[3:0];
          overflow_o <= ({1'b0, last_val} > C_MAX_CMP);
          valid_o    <= 1'b1;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Segments are computed for the digit selected after this edge so both move together
  always_comb begin
    sel_next = (refresh_cnt == C_REFRESH_LAST) ? {dig_sel_o[0], dig_sel_o[1]} : dig_sel_o;
    if (!valid_o) begin
      seg_next = C_SEG_BLANK;
    end else if (overflow_o) begin
      seg_next = C_SEG_DASH;
    end else if (sel_next == C_SEL_TENS) begin
      seg_next = (bcd_tens_o == 4'd0) ? C_SEG_BLANK : seg7(bcd_tens_o);
    end else begin
      seg_next = seg7(bcd_ones_o);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      refresh_cnt <= '0;
      dig_sel_o   <= C_SEL_ONES;
      seg_o       <= C_SEG_BLANK;
    end else begin
      refresh_cnt <= (refresh_cnt == C_REFRESH_LAST) ? '0 : refresh_cnt + C_REFRESH_ONE;
      dig_sel_o   <= sel_next;
      seg_o       <= seg_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_display_driver.sv
`default_nettype none
// tb_score_display_driver: directed stimulus with a queue-based scoreboard on
// conversion results plus direct display checks. Rev 1.0
module tb_score_display_driver;

  localparam int BW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] value;
  logic [3:0]    bcd_tens;
  logic [3:0]    bcd_ones;
  logic          valid;
  logic          busy;
  logic          overflow;
  logic [6:0]    seg;
  logic [1:0]    dig_sel;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   prev_busy   = 1'b0;

  score_display_driver #(
    .BW          (BW),
    .REFRESH_DIV (4),
    .MAX_VAL     (99)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .value_i    (value),
    .bcd_tens_o (bcd_tens),
    .bcd_ones_o (bcd_ones),
    .valid_o    (valid),
    .busy_o     (busy),
    .overflow_o (overflow),
    .seg_o      (seg),
    .dig_sel_o  (dig_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: a completed conversion shows up as busy falling outside reset
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got %0d/%0d, expected no conversion", bcd_tens, bcd_ones);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_tens",     8'(bcd_tens), 8'(mon_e.tens));
          check("sb_ones",     8'(bcd_ones), 8'(mon_e.ones));
          check("sb_overflow", 8'(overflow), 8'(mon_e.ovf));
          check("sb_valid",    8'(valid),    8'd1);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input logic lvl, input string name);
    int k = 0;
    while (busy !== lvl && k < 30) begin
      @(negedge clk);
      k++;
    end
    check(name, 8'(busy), 8'(lvl));
  endtask

  task automatic check_segs(input logic [6:0] ones_seg, input logic [6:0] tens_seg, input string name);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dig_sel == 2'b01)
        check({name, "_ones_seg"}, 8'(seg), 8'(ones_seg));
      else if (dig_sel == 2'b10)
        check({name, "_tens_seg"}, 8'(seg), 8'(tens_seg));
      else
        check({name, "_dig_sel"}, 8'(dig_sel), 8'h01);
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_seg"},      8'(seg),      8'h00);
    check({name, "_dig_sel"},  8'(dig_sel),  8'h01);
    check({name, "_tens"},     8'(bcd_tens), 8'h00);
    check({name, "_ones"},     8'(bcd_ones), 8'h00);
    check({name, "_valid"},    8'(valid),    8'h00);
    check({name, "_busy"},     8'(busy),     8'h00);
    check({name, "_overflow"}, 8'(overflow), 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int gap;
    bit seen;
    logic [1:0] last_sel;

    // 1: reset state, then first conversion of 0
    rst   = 1'b1;
    value = '0;
    repeat (3) @(negedge clk);
    check_reset_state("rst1");
    exp_q.push_back('{tens: 4'd0, ones: 4'd0, ovf: 1'b0});
    tick(1);
    rst = 1'b0;
    wait_level(1'b1, "s1_start");
    wait_level(1'b0, "s1_done");
    check_segs(7'h3F, 7'h00, "s1");

    // 2: 42, busy length and digits
    tick(1);
    value = 7'd42;
    exp_q.push_back('{tens: 4'd4, ones: 4'd2, ovf: 1'b0});
    wait_level(1'b1, "s2_start");
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("s2_busy_cycles", 8'(n), 8'd8);
    check_segs(7'h5B, 7'h66, "s2");

    // 3: digit select period
    seen     = 1'b0;
    gap      = 0;
    @(negedge clk);
    last_sel = dig_sel;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gap++;
      if (dig_sel != last_sel) begin
        if (seen) check("s3_toggle_period", 8'(gap), 8'd4);
        seen     = 1'b1;
        gap      = 0;
        last_sel = dig_sel;
      end
    end

    // 4: overflow and recovery
    tick(1);
    value = 7'd100;
    exp_q.push_back('{tens: 4'd0, ones: 4'd0, ovf: 1'b1});
    wait_level(1'b1, "s4a_start");
    wait_level(1'b0, "s4a_done");
    check_segs(7'h40, 7'h40, "s4a");
    tick(1);
    value = 7'd99;
    exp_q.push_back('{tens: 4'd9, ones: 4'd9, ovf: 1'b0});
    wait_level(1'b1, "s4b_start");
    wait_level(1'b0, "s4b_done");
    check_segs(7'h6F, 7'h6F, "s4b");

    // 5: change during SHIFT triggers automatic reconversion
    tick(1);
    value = 7'd10;
    exp_q.push_back('{tens: 4'd1, ones: 4'd0, ovf: 1'b0});
    exp_q.push_back('{tens: 4'd1, ones: 4'd1, ovf: 1'b0});
    wait_level(1'b1, "s5a_start");
    tick(2);
    value = 7'd11;
    wait_level(1'b0, "s5a_done");
    wait_level(1'b1, "s5b_start");
    wait_level(1'b0, "s5b_done");
    check_segs(7'h06, 7'h06, "s5");

    // 6: reset pulse mid-SHIFT
    tick(1);
    value = 7'd57;
    exp_q.push_back('{tens: 4'd5, ones: 4'd7, ovf: 1'b0});
    wait_level(1'b1, "s6_start");
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst6");
    tick(1);
    rst = 1'b0;
    wait_level(1'b1, "s6_restart");
    wait_level(1'b0, "s6_done");
    check_segs(7'h07, 7'h6D, "s6");

    tick(2);
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
